top_level_router_core: RTL and testbench
========================================

# top_level_router_core

Registered 1-to-4 packet router for the routing/display stage. Each cycle it accepts a 6-bit word, decodes a 2-bit destination field and writes the 4-bit payload into one of four display registers. Unaddressed registers hold their previous values. The four outputs drive the downstream display/decoder logic directly.

## Interface
Parameters:
- DATA_W, default 4: payload width and width of each display output.
- DEST_W, default 2: destination field width. Must satisfy 2**DEST_W = 4, one value per display.

Ports, one clock; reset is synchronous and active-high:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- d_in, input, 6: input word. d_in[5:4] is the destination (0..3); d_in[3:0] is the payload.
- d_disp0, output, 4: display 0 register, loaded when dest = 2'b00.
- d_disp1, output, 4: display 1 register, loaded when dest = 2'b01.
- d_disp2, output, 4: display 2 register, loaded when dest = 2'b10.
- d_disp3, output, 4: display 3 register, loaded when dest = 2'b11.

## Operation
- d_in is sampled on every rising clk edge. There is no valid/enable; every cycle is a write.
- dest = d_in[5:4] is decoded one-hot. Only d_disp[dest] loads d_in[3:0]; the other three hold.
- Payload is passed through unmodified: no inversion, no bit reordering, no arithmetic.
- Writing the same value to the same destination in consecutive cycles is harmless; the output is unchanged.
- All four destination codes are legal. No error or drop condition exists.
- Outputs come straight from flops, with no combinational path from d_in to any output.

## Timing
- Reset: when rst = 1 at a rising edge, all four outputs become 4'b0000 after that edge, whatever d_in is. Reset overrides the write in the same cycle.
- Reset mid-stream clears every display, including ones written earlier. The first post-reset write takes effect on the first edge with rst = 0.
- Latency is 1 cycle: a word present at edge N is visible on d_disp[dest] after edge N.
- Throughput is one word per cycle.
- d_in changing between edges has no effect; only the value at the rising edge matters.
- Before the first reset, output values are undefined. The bench must assert rst for at least 1 cycle first.

## Structure
- Shared package router_pkg:
  - DATA_W, DEST_W and NUM_DISP = 4.
  - Field slice constants DEST_MSB = 5, DEST_LSB = 4, DATA_MSB = 3, DATA_LSB = 0.
- Sub-module router_dec: combinational 2-to-4 one-hot decoder (dest -> load_en[3:0]).
- Top level contains:
  - four DATA_W-bit registers, each with synchronous reset and load enable;
  - the field split of d_in.

## Test plan
- Reset: hold rst = 1 for 2 cycles with d_in = 6'b111111 -> all four outputs 4'b0000.
- Sequential routing: apply 001111, 000100, 010010, 101111, 110011 on consecutive cycles. After each edge, required state:
  - disp0 = 1111 after the first word, then 0100 after the second;
  - disp1 = 0010;
  - disp2 = 1111;
  - disp3 = 0011;
  - each untouched display holds its value.
- Overwrite and hold: then apply 101101, 010110, 101111, 001001 -> final state disp0 = 1001, disp1 = 0110, disp2 = 1111, disp3 = 0011.
- Reset priority: with displays loaded, assert rst together with d_in = 6'b011010 -> all outputs 0000, and disp1 is not loaded. Deassert rst and apply 011010 -> disp1 = 1010, others remain 0000.
- Latency: change d_in mid-cycle to 6'b110101 and back to 6'b110000 before the edge -> disp3 = 0000 after the edge, not 0101. Outputs change only on rising edges.
- Exhaustive sweep: all 64 d_in values, one per cycle -> after each edge only disp[d_in[5:4]] = d_in[3:0], and the other three equal their pre-edge values.

Source files
------------

// File: rtl/router_pkg.sv
// Shared widths and d_in field positions for the 1-to-4 display router.
// No logic; constants and types only.
// Every module of the router imports this package.
package router_pkg;

    localparam int DATA_W   = 4;
    localparam int DEST_W   = 2;
    localparam int NUM_DISP = 4;

    // d_in layout: {dest[1:0], payload[3:0]}
    localparam int DEST_MSB = 5;
    localparam int DEST_LSB = 4;
    localparam int DATA_MSB = 3;
    localparam int DATA_LSB = 0;

    localparam int IN_W = DEST_W + DATA_W;

endpackage

// File: rtl/router_dec.sv
// Purpose: combinational binary-to-one-hot decode of the destination field.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the output always reflects the current destination.
module router_dec
    import router_pkg::*;
#(
    parameter int DW = DEST_W,
    parameter int ND = NUM_DISP
) (
    input  logic [DW-1:0] dest,
    output logic [ND-1:0] load_en
);

    // Exactly one load enable is raised, selected by dest; all codes are legal.
    always_comb begin
        load_en       = '0;
        load_en[dest] = 1'b1;
    end

endmodule

// File: rtl/top_level_router_core.sv
// Purpose: routes the payload of each input word into one of four display registers.
// Latency: 1 cycle from the d_in sample edge to the addressed display output.
// Backpressure: none; a word is accepted on every edge, unaddressed displays hold.
module top_level_router_core
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEST_W = router_pkg::DEST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DEST_W+DATA_W-1:0] d_in,
    output logic [DATA_W-1:0]        d_disp0,
    output logic [DATA_W-1:0]        d_disp1,
    output logic [DATA_W-1:0]        d_disp2,
    output logic [DATA_W-1:0]        d_disp3
);

    logic [DEST_W-1:0]   dest;
    logic [DATA_W-1:0]   payload;
    logic [NUM_DISP-1:0] load_en;
    logic [DATA_W-1:0]   disp_q [NUM_DISP];

    // Field split: the payload passes through untouched, no reordering.
    assign dest    = d_in[DEST_MSB:DEST_LSB];
    assign payload = d_in[DATA_MSB:DATA_LSB];

    router_dec #(
        .DW (DEST_W),
        .ND (NUM_DISP)
    ) u_dec (
        .dest    (dest),
        .load_en (load_en)
    );

    for (genvar i = 0; i < NUM_DISP; i++) begin : g_disp
        // Display register: reset wins over a same-cycle write, otherwise load when addressed.
        always_ff @(posedge clk) begin
            if (rst) begin
                disp_q[i] <= '0;
            end else if (load_en[i]) begin
                disp_q[i] <= payload;
            end
        end
    end

    // Outputs come straight from the registers; no path from d_in.
    assign d_disp0 = disp_q[0];
    assign d_disp1 = disp_q[1];
    assign d_disp2 = disp_q[2];
    assign d_disp3 = disp_q[3];

endmodule

// File: tb/tb_top_level_router_core.sv
module tb_top_level_router_core;

    logic       clk;
    logic       rst;
    logic [5:0] d_in;
    logic [3:0] d_disp0, d_disp1, d_disp2, d_disp3;

    int errors = 0;
    int checks = 0;

    // Reference state: what each display should hold.
    logic [3:0] model [4];

    typedef struct {
        logic       r;
        logic [5:0] d;
        logic [3:0] e0, e1, e2, e3;
    } vec_t;

    vec_t vecs [13];

    top_level_router_core dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .d_disp0 (d_disp0),
        .d_disp1 (d_disp1),
        .d_disp2 (d_disp2),
        .d_disp3 (d_disp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2, input logic [3:0] e3);
        chk({tag, ".disp0"}, d_disp0, e0);
        chk({tag, ".disp1"}, d_disp1, e1);
        chk({tag, ".disp2"}, d_disp2, e2);
        chk({tag, ".disp3"}, d_disp3, e3);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic r, input logic [5:0] d);
        @(negedge clk);
        rst  = r;
        d_in = d;
        @(posedge clk);
        #1;
    endtask

    // Behavioural rule: reset clears all, otherwise only display[dest] takes the payload.
    task automatic model_step(input logic r, input logic [5:0] d);
        int dst;
        if (r) begin
            for (int k = 0; k < 4; k++) model[k] = 4'b0000;
        end else begin
            dst = int'(d) / 16;
            model[dst] = 4'(int'(d) % 16);
        end
    endtask

    initial begin
        rst  = 1'b1;
        d_in = 6'b111111;

        vecs[0]  = '{1'b1, 6'b111111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b1, 6'b111111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{1'b0, 6'b001111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b0, 6'b000100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        vecs[4]  = '{1'b0, 6'b010010, 4'b0100, 4'b0010, 4'b0000, 4'b0000};
        vecs[5]  = '{1'b0, 6'b101111, 4'b0100, 4'b0010, 4'b1111, 4'b0000};
        vecs[6]  = '{1'b0, 6'b110011, 4'b0100, 4'b0010, 4'b1111, 4'b0011};
        vecs[7]  = '{1'b0, 6'b101101, 4'b0100, 4'b0010, 4'b1101, 4'b0011};
        vecs[8]  = '{1'b0, 6'b010110, 4'b0100, 4'b0110, 4'b1101, 4'b0011};
        vecs[9]  = '{1'b0, 6'b101111, 4'b0100, 4'b0110, 4'b1111, 4'b0011};
        vecs[10] = '{1'b0, 6'b001001, 4'b1001, 4'b0110, 4'b1111, 4'b0011};
        vecs[11] = '{1'b1, 6'b011010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[12] = '{1'b0, 6'b011010, 4'b0000, 4'b1010, 4'b0000, 4'b0000};

        // Directed table: reset, routing, overwrite/hold, reset priority.
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].r, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
        end

        // Only the value at the rising edge counts; outputs must not move mid-cycle.
        @(negedge clk);
        rst  = 1'b0;
        d_in = 6'b110000;
        #1 d_in = 6'b110101;
        #1;
        chk("midcycle.disp3", d_disp3, 4'b0000);
        #1 d_in = 6'b110000;
        @(posedge clk);
        #1;
        chk_all("glitch", 4'b0000, 4'b1010, 4'b0000, 4'b0000);

        model[0] = 4'b0000;
        model[1] = 4'b1010;
        model[2] = 4'b0000;
        model[3] = 4'b0000;

        // Exhaustive sweep of all 64 input words.
        for (int v = 0; v < 64; v++) begin
            apply(1'b0, 6'(v));
            model_step(1'b0, 6'(v));
            chk_all($sformatf("sweep%0d", v), model[0], model[1], model[2], model[3]);
        end

        // Random traffic with occasional reset.
        for (int n = 0; n < 300; n++) begin
            logic       r;
            logic [5:0] d;
            r = ($urandom_range(0, 15) == 0);
            d = 6'($urandom_range(0, 63));
            apply(r, d);
            model_step(r, d);
            chk_all($sformatf("rand%0d", n), model[0], model[1], model[2], model[3]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
